ps2_host_tx: RTL and testbench

- Host-to-device PS/2 transmitter. It is the opposite direction to the existing keyboard receiver on the same two-wire bus.
- Sends one command byte to the keyboard, for example 0xED (set LEDs), 0xFF (reset) or 0xF3 (typematic).
- Runs on the 7 MHz video/keyboard clock.
- Drives the open-drain ps2 clock and data lines through output-enable pins. The top level combines these with the receiver's inputs.

---
 rtl/ps2_host_tx_pkg.sv | 23 ++
 rtl/ps2_host_tx_sync.sv | 58 +++++
 rtl/ps2_host_tx.sv | 170 +++++++++++++++++
 tb/tb_ps2_host_tx.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_host_tx_pkg.sv
// Shared PS/2 definitions: transmitter states, default timing and frame builder.
// The keyboard receiver imports the same package.
package ps2_host_tx_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REL,
        S_BITS,
        S_ACK,
        S_WAITREL
    } state_e;

    localparam int INHIBIT_CYC = 840;
    localparam int TIMEOUT_CYC = 140000;
    localparam int FILTER_LEN  = 8;

    // {stop, odd parity, data}, shifted out LSB first
    function automatic logic [9:0] ps2_frame(input logic [7:0] b);
        return {1'b1, ~^b, b};
    endfunction

endpackage

// File: rtl/ps2_host_tx_sync.sv
// PS/2 line conditioner: 2-FF synchroniser, run-length glitch filter
// and registered falling-edge pulse on the filtered level.
module ps2_sync
    import ps2_host_tx_pkg::*;
#(
    parameter int FILTER = FILTER_LEN
) (
    input  logic clock,
    input  logic reset,
    input  logic line_i,
    output logic level_o,
    output logic fall_o
);

    localparam int CW = $clog2(FILTER) + 1;

    logic          s1_q, s1_d;
    logic          s2_q, s2_d;
    logic          lvl_q, lvl_d;
    logic          fall_q, fall_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        s1_d  = line_i;
        s2_d  = s1_q;
        lvl_d = lvl_q;
        cnt_d = '0;
        if (s2_q != lvl_q) begin
            if (cnt_q == CW'(FILTER - 1)) begin
                lvl_d = s2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        fall_d = lvl_q & ~lvl_d;
    end

    // Idle bus level is high, so start from 1 to avoid a fake edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_q   <= 1'b1;
            s2_q   <= 1'b1;
            lvl_q  <= 1'b1;
            fall_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            lvl_q  <= lvl_d;
            fall_q <= fall_d;
            cnt_q  <= cnt_d;
        end
    end

    assign level_o = lvl_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, sends one command
// byte on device clock falls, checks the device ack, with a global timeout.
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int INHIBIT = INHIBIT_CYC,
    parameter int TIMEOUT = TIMEOUT_CYC,
    parameter int FILTER  = FILTER_LEN
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] d,
    input  logic       ps2CkI,
    input  logic       ps2DtI,
    output logic       ps2CkOe,
    output logic       ps2DtOe,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int IW = $clog2(INHIBIT + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic ck_lvl, ck_fall;
    logic dt_lvl, dt_fall_unused;

    ps2_sync #(.FILTER(FILTER)) u_ck (
        .clock  (clock),
        .reset  (reset),
        .line_i (ps2CkI),
        .level_o(ck_lvl),
        .fall_o (ck_fall)
    );

    ps2_sync #(.FILTER(FILTER)) u_dt (
        .clock  (clock),
        .reset  (reset),
        .line_i (ps2DtI),
        .level_o(dt_lvl),
        .fall_o (dt_fall_unused)
    );

    state_e        state_q, state_d;
    logic [9:0]    shift_q, shift_d;
    logic [3:0]    bcnt_q, bcnt_d;
    logic [IW-1:0] icnt_q, icnt_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          ck_oe_q, ck_oe_d;
    logic          dt_oe_q, dt_oe_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          running;
    logic          timed_out;

    assign running   = state_q inside {S_REL, S_BITS, S_ACK, S_WAITREL};
    assign timed_out = running && (tcnt_q == TW'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bcnt_d  = bcnt_q;
        icnt_d  = icnt_q;
        tcnt_d  = tcnt_q;
        ck_oe_d = ck_oe_q;
        dt_oe_d = dt_oe_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        // Timeout has priority over any device edge in the same cycle.
        if (timed_out) begin
            state_d = S_IDLE;
            ck_oe_d = 1'b0;
            dt_oe_d = 1'b0;
            busy_d  = 1'b0;
            err_d   = 1'b1;
        end else begin
            if (running) begin
                tcnt_d = tcnt_q + 1'b1;
            end
            unique case (state_q)
                S_IDLE: begin
                    if (start && !done_q && !err_q) begin
                        shift_d = ps2_frame(d);
                        busy_d  = 1'b1;
                        icnt_d  = '0;
                        ck_oe_d = 1'b1;
                        state_d = S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    if (icnt_q == IW'(INHIBIT - 1)) begin
                        ck_oe_d = 1'b0;
                        dt_oe_d = 1'b1;
                        tcnt_d  = '0;
                        bcnt_d  = '0;
                        state_d = S_REL;
                    end else begin
                        icnt_d = icnt_q + 1'b1;
                    end
                end
                S_REL: state_d = S_BITS;
                S_BITS: begin
                    if (ck_fall) begin
                        dt_oe_d = ~shift_q[0];
                        shift_d = {1'b0, shift_q[9:1]};
                        bcnt_d  = bcnt_q + 1'b1;
                        if (bcnt_q == 4'd9) begin
                            state_d = S_ACK;
                        end
                    end
                end
                S_ACK: begin
                    if (ck_fall) begin
                        if (!dt_lvl) begin
                            state_d = S_WAITREL;
                        end else begin
                            err_d   = 1'b1;
                            busy_d  = 1'b0;
                            state_d = S_IDLE;
                        end
                    end
                end
                S_WAITREL: begin
                    if (ck_lvl && dt_lvl) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            bcnt_q  <= '0;
            icnt_q  <= '0;
            tcnt_q  <= '0;
            ck_oe_q <= 1'b0;
            dt_oe_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bcnt_q  <= bcnt_d;
            icnt_q  <= icnt_d;
            tcnt_q  <= tcnt_d;
            ck_oe_q <= ck_oe_d;
            dt_oe_q <= dt_oe_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign ps2CkOe = ck_oe_q;
    assign ps2DtOe = dt_oe_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign error   = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural PS/2 device on an
// open-drain (wired-AND) bus.
module tb_ps2_host_tx;

    localparam int INH = 840;
    localparam int TMO = 14000;
    localparam int FLT = 8;
    localparam int HP_SLOW = 292;
    localparam int HP_FAST = 100;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] d = 8'h00;
    logic       dev_ck = 1'b1;
    logic       dev_dt = 1'b1;
    logic       ps2CkOe, ps2DtOe, busy, done, error;
    logic       ck_line, dt_line;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int err_cnt = 0;

    assign ck_line = dev_ck & ~ps2CkOe;
    assign dt_line = dev_dt & ~ps2DtOe;

    always #5 clock = ~clock;

    ps2_host_tx #(
        .INHIBIT(INH),
        .TIMEOUT(TMO),
        .FILTER (FLT)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .d      (d),
        .ps2CkI (ck_line),
        .ps2DtI (dt_line),
        .ps2CkOe(ps2CkOe),
        .ps2DtOe(ps2DtOe),
        .busy   (busy),
        .done   (done),
        .error  (error)
    );

    always @(negedge clock) begin
        if (done) done_cnt = done_cnt + 1;
        if (error) err_cnt = err_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic send_start(input logic [7:0] b);
        d = b;
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    // Measures the clock-inhibit length; optionally fires a second start.
    task automatic check_inhibit(input string tag, input bit inj);
        int n;
        n = 0;
        while (ps2CkOe && n < 2000) begin
            if (inj && n == 100) begin
                d = 8'hAA;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick(1);
            n++;
        end
        start = 1'b0;
        check({tag, "_inhibit"}, 32'(n), 32'(INH));
        check({tag, "_startbit"}, 32'(ps2DtOe), 32'd1);
    endtask

    task automatic dev_bits(input int hp, input int nbits, input int gmask,
                            output logic [9:0] bits);
        bits = '0;
        for (int i = 0; i < nbits; i++) begin
            dev_ck = 1'b0;
            tick(hp);
            dev_ck = 1'b1;
            bits[i] = dt_line;
            if (gmask[i]) begin
                tick(hp / 2);
                dev_ck = 1'b0;
                tick(3);
                dev_ck = 1'b1;
                tick(hp - hp / 2 - 3);
            end else begin
                tick(hp);
            end
        end
    endtask

    task automatic dev_ack(input int hp);
        dev_dt = 1'b0;
        tick(hp / 2);
        dev_ck = 1'b0;
        tick(hp);
        dev_ck = 1'b1;
        tick(hp / 2);
        dev_dt = 1'b1;
    endtask

    task automatic run_frame(input string tag, input logic [7:0] b,
                             input logic [9:0] exp, input int hp,
                             input int gmask, input bit inj, input bit late);
        logic [9:0] bits;
        int n;
        int d0;
        int e0;
        d0 = done_cnt;
        e0 = err_cnt;
        send_start(b);
        check_inhibit(tag, inj);
        tick(hp);
        dev_bits(hp, 10, gmask, bits);
        check({tag, "_frame"}, 32'(bits), 32'(exp));
        dev_ack(hp);
        n = 0;
        while (!done && n < 200) begin
            tick(1);
            n++;
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        if (late) begin
            d = 8'hAA;
            start = 1'b1;
            tick(1);
            start = 1'b0;
            check({tag, "_late_busy"}, 32'(busy), 32'd0);
            tick(2);
            check({tag, "_late_ckoe"}, 32'(ps2CkOe), 32'd0);
        end
        tick(2);
        check({tag, "_ndone"}, 32'(done_cnt - d0), 32'd1);
        check({tag, "_nerr"}, 32'(err_cnt - e0), 32'd0);
    endtask

    initial begin
        logic [9:0] bits;
        int n;
        int d0;
        int e0;

        tick(3);
        check("rst_ckoe", 32'(ps2CkOe), 32'd0);
        check("rst_dtoe", 32'(ps2DtOe), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        reset = 1'b0;
        tick(20);

        run_frame("ed", 8'hED, 10'h3ED, HP_SLOW, 0, 1'b0, 1'b0);
        tick(50);
        run_frame("x00", 8'h00, 10'h300, HP_FAST, 0, 1'b0, 1'b0);
        tick(50);
        run_frame("x01", 8'h01, 10'h201, HP_FAST, 0, 1'b0, 1'b1);
        tick(50);
        run_frame("xff", 8'hFF, 10'h3FF, HP_FAST, 0, 1'b0, 1'b0);
        tick(50);

        // device never clocks
        d0 = done_cnt;
        e0 = err_cnt;
        send_start(8'h55);
        check_inhibit("tmo", 1'b0);
        n = 0;
        while (!error && n < TMO + 100) begin
            tick(1);
            n++;
        end
        check("tmo_latency", 32'(n), 32'(TMO));
        check("tmo_ckoe", 32'(ps2CkOe), 32'd0);
        check("tmo_dtoe", 32'(ps2DtOe), 32'd0);
        check("tmo_busy", 32'(busy), 32'd0);
        tick(2);
        check("tmo_nerr", 32'(err_cnt - e0), 32'd1);
        check("tmo_ndone", 32'(done_cnt - d0), 32'd0);
        tick(50);

        // device omits the ack on the 11th fall
        d0 = done_cnt;
        e0 = err_cnt;
        send_start(8'h12);
        check_inhibit("noack", 1'b0);
        tick(HP_FAST);
        dev_bits(HP_FAST, 10, 0, bits);
        check("noack_frame", 32'(bits), 32'h312);
        dev_ck = 1'b0;
        n = 0;
        while (!error && n < 200) begin
            tick(1);
            n++;
        end
        check("noack_latency", 32'(n), 32'(FLT + 3));
        check("noack_busy", 32'(busy), 32'd0);
        tick(HP_FAST);
        dev_ck = 1'b1;
        tick(20);
        check("noack_nerr", 32'(err_cnt - e0), 32'd1);
        check("noack_ndone", 32'(done_cnt - d0), 32'd0);
        tick(50);

        // reset while the bit-5 clock is low
        d0 = done_cnt;
        e0 = err_cnt;
        send_start(8'h5A);
        check_inhibit("rstmid", 1'b0);
        tick(HP_FAST);
        dev_bits(HP_FAST, 5, 0, bits);
        check("rstmid_bits", 32'(bits), 32'h01A);
        dev_ck = 1'b0;
        tick(HP_FAST / 2);
        reset = 1'b1;
        tick(1);
        check("rstmid_ckoe", 32'(ps2CkOe), 32'd0);
        check("rstmid_dtoe", 32'(ps2DtOe), 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        dev_ck = 1'b1;
        tick(30);
        check("rstmid_nerr", 32'(err_cnt - e0), 32'd0);
        check("rstmid_ndone", 32'(done_cnt - d0), 32'd0);
        run_frame("f3", 8'hF3, 10'h3F3, HP_FAST, 0, 1'b0, 1'b0);
        tick(50);

        // second start while busy, plus short clock glitches
        run_frame("busyg", 8'hED, 10'h3ED, HP_FAST, 10'b00_0010_0100,
                  1'b1, 1'b0);
        tick(1000);
        check("busyg_idle_busy", 32'(busy), 32'd0);
        check("busyg_idle_ckoe", 32'(ps2CkOe), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
